// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
// Optional protocol checking is enabled by defining FETCH_PROTOCOL_CHECK_EN.
package fetch_pkg;

    localparam int PC_BITS    = 64;
    localparam int INSN_BITS  = 32;
    localparam int INSN_BYTES = INSN_BITS / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_BITS-1:0]   pc;
        logic [INSN_BITS-1:0] insn;
    } fetch_entry_t;

    // Memory returns the lowest-addressed byte in the top lane; instructions are little-endian.
    function automatic logic [INSN_BITS-1:0] byte_reverse32(input logic [INSN_BITS-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-write / one-read instruction FIFO with flush, occupancy and free-space outputs.
// Overflow is checked when FETCH_PROTOCOL_CHECK_EN is defined.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr0_en,
    input  fetch_entry_t           wr0_data,
    input  logic                   wr1_en,
    input  fetch_entry_t           wr1_data,
    input  logic                   rd_en,
    output fetch_entry_t           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic [CW-1:0] wr1_ptr;

    // The extra pointer bit distinguishes full from empty.
    assign wr1_ptr = wr0_en ? wptr + CW'(1) : wptr;
    assign count   = wptr - rptr;
    assign free    = CW'(DEPTH) - count;
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem[wptr[AW-1:0]] <= wr0_data;
        end
        if (wr1_en) begin
            mem[wr1_ptr[AW-1:0]] <= wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + CW'(wr0_en) + CW'(wr1_en);
            if (rd_en) begin
                rptr <= rptr + CW'(1);
            end
        end
    end

`ifdef FETCH_PROTOCOL_CHECK_EN
    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (int'(count) + int'(wr0_en) + int'(wr1_en) - int'(rd_en) <= DEPTH)
                else $fatal(1, "fetch_buffer overflow");
        end
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues 64-bit fetches, splits them into two
// instructions and queues them for decode. Checks enabled by FETCH_PROTOCOL_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    FETCH_WIDTH = 64,
    parameter int                    INSN_WIDTH  = 32,
    parameter int                    BUF_DEPTH   = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_rd_en_o,
    output logic [DATA_WIDTH-1:0]      imem_addr_o,
    input  logic                       imem_busy_i,
    input  logic                       imem_rdy_i,
    input  logic [FETCH_WIDTH-1:0]     imem_rd_data_i,
    input  logic                       redirect_i,
    input  logic [DATA_WIDTH-1:0]      redirect_pc_i,
    output logic                       insn_valid_o,
    output logic [INSN_WIDTH-1:0]      insn_o,
    output logic [DATA_WIDTH-1:0]      insn_pc_o,
    input  logic                       insn_ready_i,
    output fetch_state_e               dbg_state_o,
    output logic [$clog2(BUF_DEPTH):0] dbg_count_o
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e          state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_base;
    logic [CW-1:0]         count;
    logic [CW-1:0]         free;
    logic                  fetch_done;
    logic                  wr0_en;
    logic                  deq;
    fetch_entry_t          wr0_data;
    fetch_entry_t          wr1_data;
    fetch_entry_t          head;
    logic                  unused_bits;

    assign pc_base     = {pc[DATA_WIDTH-1:3], 3'b000};
    assign imem_addr_o = pc_base;

    // Only issue when both halves of the fetch are guaranteed a slot.
    assign imem_rd_en_o = (state == IDLE) && !imem_busy_i && (free >= CW'(2))
                          && !redirect_i && !rst;

    assign fetch_done = (state == WAIT) && imem_rdy_i && !redirect_i;
    assign wr0_en     = fetch_done && !pc[2];

    assign wr0_data.pc   = PC_BITS'(pc_base);
    assign wr0_data.insn = byte_reverse32(imem_rd_data_i[63:32]);
    assign wr1_data.pc   = PC_BITS'(pc_base + DATA_WIDTH'(INSN_BYTES));
    assign wr1_data.insn = byte_reverse32(imem_rd_data_i[31:0]);

    // Decode handshake: an entry transfers in any cycle where insn_valid_o and
    // insn_ready_i are both high; a redirect hides the head so nothing transfers.
    assign insn_valid_o = (count != '0) && !redirect_i;
    assign deq          = insn_valid_o && insn_ready_i;
    assign insn_o       = INSN_WIDTH'(head.insn);
    assign insn_pc_o    = DATA_WIDTH'(head.pc);

    assign dbg_state_o = state;
    assign dbg_count_o = count;
    assign unused_bits = ^redirect_pc_i[1:0];

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_i),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (fetch_done),
        .wr1_data (wr1_data),
        .rd_en    (deq),
        .rd_data  (head),
        .count    (count),
        .free     (free)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else if (redirect_i) begin
            pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            // A killed request must still be drained from memory before reissuing.
            case (state)
                WAIT:    state <= imem_rdy_i ? IDLE : DROP;
                DROP:    state <= imem_rdy_i ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (imem_rd_en_o) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rdy_i) begin
                        pc    <= pc_base + DATA_WIDTH'(8);
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (imem_rdy_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PROTOCOL_CHECK_EN
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rdy_i && state == IDLE))
                else $fatal(1, "imem_rdy_i with no request outstanding");
            assert (!(imem_rd_en_o && imem_busy_i))
                else $fatal(1, "imem_rd_en_o while memory busy");
            assert (!(insn_valid_o && insn_pc_o[1:0] != 2'b00))
                else $fatal(1, "misaligned instruction PC at buffer head");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural memory, transaction-level reference model with
// an expected-entry queue, directed scenarios followed by randomized traffic.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DW        = 64;
    localparam int          BUF_DEPTH = 4;
    localparam int          CW        = $clog2(BUF_DEPTH) + 1;
    localparam int          EW        = 96;
    localparam logic [63:0] RESET_PC  = 64'h0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          imem_rd_en_o;
    logic [DW-1:0] imem_addr_o;
    logic          imem_busy_i    = 1'b0;
    logic          imem_rdy_i     = 1'b0;
    logic [63:0]   imem_rd_data_i = '0;
    logic          redirect_i     = 1'b0;
    logic [DW-1:0] redirect_pc_i  = '0;
    logic          insn_valid_o;
    logic [31:0]   insn_o;
    logic [DW-1:0] insn_pc_o;
    logic          insn_ready_i   = 1'b0;
    fetch_state_e  dbg_state_o;
    logic [CW-1:0] dbg_count_o;

    fetch_unit #(
        .DATA_WIDTH  (DW),
        .FETCH_WIDTH (64),
        .INSN_WIDTH  (32),
        .BUF_DEPTH   (BUF_DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_rd_en_o   (imem_rd_en_o),
        .imem_addr_o    (imem_addr_o),
        .imem_busy_i    (imem_busy_i),
        .imem_rdy_i     (imem_rdy_i),
        .imem_rd_data_i (imem_rd_data_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .insn_valid_o   (insn_valid_o),
        .insn_o         (insn_o),
        .insn_pc_o      (insn_pc_o),
        .insn_ready_i   (insn_ready_i),
        .dbg_state_o    (dbg_state_o),
        .dbg_count_o    (dbg_count_o)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Reference model: expected buffer contents {pc, insn}, PC, outstanding request.
    logic [EW-1:0] exp_q[$];
    logic [63:0]   m_pc    = RESET_PC;
    bit            req_out = 1'b0;
    bit            req_live = 1'b0;

    // Behavioural memory state (reacts to the DUT's own requests).
    bit          mem_pend  = 1'b0;
    int          mem_cnt   = 0;
    int          mem_lat   = 2;
    logic [63:0] mem_addr  = '0;
    bit          rand_busy = 1'b0;

    // Observations for directed checks.
    logic [63:0]   issue_addr[$];
    int            issue_cyc[$];
    logic [EW-1:0] got_q[$];

    bit          r_rst;
    bit          r_redir;
    bit          r_rdy;
    logic [63:0] r_pc;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [7:0] boot [8];
        boot = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        if (a < 64'd8) return boot[a[2:0]];
        return 8'(a * 64'd37) ^ a[15:8] ^ a[63:56] ^ 8'h5a;
    endfunction

    function automatic logic [63:0] mem_line(input logic [63:0] a);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[63-8*k -: 8] = mem_byte(a + 64'(k));
        return d;
    endfunction

    function automatic logic [31:0] insn_at(input logic [63:0] p);
        return {mem_byte(p + 64'd3), mem_byte(p + 64'd2), mem_byte(p + 64'd1), mem_byte(p)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_got(input string tag, input int idx, input logic [63:0] pc_e,
                             input logic [31:0] insn_e);
        logic [EW-1:0] g;
        g = (got_q.size() > idx) ? got_q[idx] : '0;
        check({tag, "_pc"}, g[95:32], pc_e);
        check({tag, "_insn"}, 64'(g[31:0]), 64'(insn_e));
    endtask

    function automatic logic [63:0] iss_at(input int idx);
        return (issue_addr.size() > idx) ? issue_addr[idx] : 64'hdead_beef_dead_beef;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input bit r, input bit redir, input logic [63:0] rpc, input bit rdy);
        bit           exp_en;
        bit           exp_v;
        fetch_state_e exp_st;
        logic [63:0]  base;

        rst           = r;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        insn_ready_i  = rdy;
        imem_rdy_i     = 1'b0;
        imem_rd_data_i = {$urandom, $urandom};
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rdy_i     = 1'b1;
                imem_rd_data_i = mem_line(mem_addr);
            end
        end
        imem_busy_i = mem_pend || rand_busy;

        @(negedge clk);
        exp_en = !req_out && !imem_busy_i && (exp_q.size() <= BUF_DEPTH - 2) && !redir && !r;
        exp_v  = (exp_q.size() != 0) && !redir;
        exp_st = !req_out ? IDLE : (req_live ? WAIT : DROP);
        if (chk_en) begin
            check("rd_en", 64'(imem_rd_en_o), 64'(exp_en));
            check("addr", imem_addr_o, {m_pc[63:3], 3'b000});
            check("valid", 64'(insn_valid_o), 64'(exp_v));
            if (exp_v) begin
                check("insn", 64'(insn_o), 64'(exp_q[0][31:0]));
                check("insn_pc", insn_pc_o, exp_q[0][95:32]);
            end
            check("state", 64'(dbg_state_o), 64'(exp_st));
            check("count", 64'(dbg_count_o), 64'(exp_q.size()));
        end

        // memory environment
        if (r) begin
            mem_pend = 1'b0;
        end else begin
            if (imem_rdy_i) mem_pend = 1'b0;
            if (imem_rd_en_o) begin
                mem_pend = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = imem_addr_o;
                issue_addr.push_back(imem_addr_o);
                issue_cyc.push_back(cyc);
            end
            if (insn_valid_o && insn_ready_i) got_q.push_back({insn_pc_o, insn_o});
        end

        // reference model
        if (r) begin
            exp_q.delete();
            m_pc     = RESET_PC;
            req_out  = 1'b0;
            req_live = 1'b0;
        end else begin
            if (exp_v && rdy) void'(exp_q.pop_front());
            if (imem_rdy_i && req_out) begin
                if (req_live && !redir) begin
                    base = {m_pc[63:3], 3'b000};
                    if (!m_pc[2]) exp_q.push_back({base, insn_at(base)});
                    exp_q.push_back({base + 64'd4, insn_at(base + 64'd4)});
                    m_pc = base + 64'd8;
                end
                req_out  = 1'b0;
                req_live = 1'b0;
            end
            if (redir) begin
                exp_q.delete();
                m_pc     = {rpc[63:2], 2'b00};
                req_live = 1'b0;
            end
            if (exp_en) begin
                req_out  = 1'b1;
                req_live = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'h0, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 64'h0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 64'h0, 1'b0);
        issue_addr.delete();
        issue_cyc.delete();
        got_q.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // Boot fetch: two instructions from address 0, next request 3 cycles later.
        do_reset();
        check("rst_valid", 64'(insn_valid_o), 64'h0);
        run(10, 1'b1);
        check("boot_addr0", iss_at(0), 64'h0);
        check("boot_addr1", iss_at(1), 64'h8);
        check("boot_gap", 64'((issue_cyc.size() > 1) ? issue_cyc[1] - issue_cyc[0] : -1), 64'd3);
        check_got("boot0", 0, 64'h0, 32'h0000_0013);
        check_got("boot1", 1, 64'h4, 32'h0010_0093);

        // Stalled decode fills the buffer with exactly two fetches.
        do_reset();
        run(20, 1'b0);
        check("stall_issues", 64'(issue_addr.size()), 64'd2);
        check("stall_count", 64'(dbg_count_o), 64'd4);
        run(8, 1'b1);
        check_got("drain0", 0, 64'h0, insn_at(64'h0));
        check_got("drain1", 1, 64'h4, insn_at(64'h4));
        check_got("drain2", 2, 64'h8, insn_at(64'h8));
        check_got("drain3", 3, 64'hC, insn_at(64'hC));

        // Redirect while waiting: returned data dropped, restart mid-line.
        do_reset();
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b1, 64'h104, 1'b1);
        check("drop_state", 64'(dbg_state_o), 64'(DROP));
        issue_addr.delete();
        run(12, 1'b1);
        check("drop_reissue", iss_at(0), 64'h100);
        check_got("drop_first", 0, 64'h104, insn_at(64'h104));

        // Redirect coincident with read data.
        do_reset();
        run(2, 1'b1);
        step(1'b0, 1'b1, 64'h200, 1'b1);
        check("rr_count", 64'(dbg_count_o), 64'd0);
        issue_addr.delete();
        run(1, 1'b1);
        check("rr_issue", iss_at(0), 64'h200);
        run(6, 1'b1);

        // Redirect beats dequeue.
        do_reset();
        run(4, 1'b0);
        got_q.delete();
        step(1'b0, 1'b1, 64'h300, 1'b1);
        check("rd_no_deq", 64'(got_q.size()), 64'd0);
        check("rd_flush", 64'(dbg_count_o), 64'd0);
        run(8, 1'b1);

        // Reset while waiting.
        do_reset();
        run(1, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        check("rw_state", 64'(dbg_state_o), 64'(IDLE));
        check("rw_valid", 64'(insn_valid_o), 64'h0);
        issue_addr.delete();
        run(1, 1'b0);
        check("rw_issue", iss_at(0), RESET_PC);
        run(6, 1'b1);

        // PC wrap past all-ones.
        do_reset();
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        issue_addr.delete();
        got_q.delete();
        run(10, 1'b1);
        check("wrap_addr0", iss_at(0), 64'hFFFF_FFFF_FFFF_FFF8);
        check("wrap_addr1", iss_at(1), 64'h0);
        check_got("wrap0", 0, 64'hFFFF_FFFF_FFFF_FFFC, insn_at(64'hFFFF_FFFF_FFFF_FFFC));
        check_got("wrap1", 1, 64'h0, insn_at(64'h0));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            rand_busy = ($urandom_range(0, 7) == 0);
            mem_lat   = $urandom_range(2, 4);
            r_rst     = ($urandom_range(0, 199) == 0);
            r_redir   = ($urandom_range(0, 29) == 0);
            r_pc      = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                    : 64'($urandom_range(0, 255));
            r_rdy     = ($urandom_range(0, 9) < 7);
            step(r_rst, r_redir, r_pc, r_rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
